bus_arb_mux: RTL
================

# bus_arb_mux

Parametrised N-input bus multiplexer with valid/ready handshake, packet-aware arbitration and a registered output stage. It succeeds the 2:1 select-driven bus mux where several producers (DMA, CPU port, debug port) share one downstream bus: the select is generated internally by an arbiter rather than supplied by the user. A grant is held for a whole packet (up to `in_last`) so multi-beat transfers are never interleaved.

## Interface
- `BUS_WIDTH`, 32: data width per channel, in bits.
- `N_INPUTS`, 4: number of input channels, at least 2.
- `ARB_MODE`, 1: arbitration mode, 0 = fixed priority (index 0 highest), 1 = round-robin.
- `SEL_WIDTH`, clog2(N_INPUTS): derived, do not override.

- `clk`  in  1  single clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  N_INPUTS*BUS_WIDTH  channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- `in_valid`  in  N_INPUTS  channel i offers a beat.
- `in_last`  in  N_INPUTS  beat is the final beat of its packet.
- `in_ready`  out  N_INPUTS  channel i beat accepted this cycle when valid&ready.
- `out_data`  out  BUS_WIDTH  registered output beat.
- `out_valid`  out  1  output beat valid.
- `out_last`  out  1  registered copy of the accepted beat's `in_last`.
- `out_sel`  out  SEL_WIDTH  index of the channel that produced the current output beat.
- `out_ready`  in  1  downstream accepts beat.

## Operation
- `can_load = !out_valid || out_ready`; output register loads only when `can_load`.
- FSM states: IDLE, LOCKED. Registers: `state`, `lock_idx`, `rr_ptr`.
- IDLE: arbiter picks grant g among asserted `in_valid`; fixed mode searches from 0 upward; round-robin searches from `rr_ptr` upward, wrapping at N_INPUTS-1 -> 0. If no valid, no grant, all `in_ready` = 0.
- LOCKED: g = `lock_idx` regardless of other requests.
- `in_ready[g] = can_load` (and in IDLE only if `in_valid[g]`); all other `in_ready` bits 0. At most one `in_ready` bit high per cycle.
- On transfer from g: out_data/out_last/out_sel <= channel g beat, out_valid <= 1.
  - `in_last`=0: state <= LOCKED, `lock_idx` <= g.
  - `in_last`=1: state <= IDLE; `rr_ptr` <= (g+1) mod N_INPUTS (round-robin only; unchanged in fixed mode).
- No transfer and `out_ready`=1: out_valid <= 0; data/last/sel hold.
- LOCKED with `in_valid[lock_idx]`=0: bubble, grant still held, other channels wait.
- `rr_ptr` wrap: g = N_INPUTS-1 sets `rr_ptr` to 0; non-power-of-two N_INPUTS must wrap explicitly.
- Upstream must hold data/last stable while valid and not ready; block does not check this.

## Timing
- Reset (async assert, sync-released by system): state IDLE, `rr_ptr` 0, `lock_idx` 0, out_valid 0, out_data 0, out_last 0, out_sel 0. Asserting `rst_n` mid-packet abandons the packet; no beat is emitted after reset until a new transfer.
- Latency: input transfer in cycle n -> `out_valid` in cycle n+1.
- Throughput: one beat per cycle sustained while `out_ready`=1.
- `in_ready` is combinational from `out_ready`, `in_valid`, state and `rr_ptr`; no combinational path from `in_data` to any output.
- Simultaneous: last beat accepted and another channel valid in same cycle -> new grant computed next cycle from updated `rr_ptr` (one-cycle arbitration gap not permitted for same channel only if it is still highest priority; otherwise normal).
- Backpressure: `out_ready`=0 with out_valid=1 -> output held, all `in_ready`=0.

## Structure
- Shared package `bus_pkg`: FSM state encoding (IDLE=0, LOCKED=1), ARB_MODE constants (ARB_FIXED, ARB_RR), clog2 function.
- One sub-module: `rr_arbiter` (N-wide request vector, base pointer, mode -> one-hot grant and encoded index). Top holds FSM, lock and output register.

## Test plan
- Reset: drive `rst_n`=0 with all inputs random -> all outputs 0, all `in_ready` 0.
- Single beat: ch2 valid, last=1, data 0xA5A5_0002, out_ready=1 -> `in_ready`=4'b0100 cycle n, out_data=0xA5A5_0002, out_sel=2, out_last=1 cycle n+1.
- Round-robin fairness: all 4 channels continuously valid single-beat, out_ready=1 -> out_sel sequence 0,1,2,3,0,1; in fixed mode -> always 0.
- Packet lock: ch1 sends 3-beat packet, ch0 valid throughout -> three consecutive ch1 beats (last on third), then ch0; ch1 drop of valid mid-packet inserts bubble, ch0 still blocked.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_data stable, `in_ready`=0; release -> no beat lost or duplicated (compare against scoreboard).
- Reset mid-packet: assert `rst_n`=0 after beat 2 of 4 -> out_valid 0 immediately, state IDLE; after release, ch3 single beat wins from `rr_ptr`=0 order.

Source files
------------

// File: rtl/bus_arb_mux_pkg.sv
// Shared definitions for the bus_arb_mux slice.
//   state_t   : grant FSM encoding (IDLE = 0, LOCKED = 1)
//   ARB_FIXED : fixed-priority arbitration, index 0 highest
//   ARB_RR    : round-robin arbitration
//   clog2()   : elaboration-time ceiling log2 used to size select fields
package bus_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Smallest r with 2**r >= n; used only on constant parameters.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_arb_mux_if.sv
// Bus bundle between N upstream producers, the arbitrating mux and the
// downstream consumer.
//   in_data/in_valid/in_last : upstream beats, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   in_ready                 : per-channel accept, at most one bit high
//   out_data/out_valid/out_last/out_sel : registered downstream beat
//   out_ready                : downstream accept
// Handshake: a beat moves on a rising edge where valid and ready are both 1;
// a producer holds data/last stable while valid is high and ready is low.
// Modports: slave = mux view, master = producer/consumer (environment) view.
interface bus_arb_mux_if
   import bus_pkg::*;
#(
   parameter int BUS_WIDTH = 32,
   parameter int N_INPUTS  = 4,
   parameter int SEL_WIDTH = clog2(N_INPUTS)
);

   logic [N_INPUTS*BUS_WIDTH-1:0] in_data;
   logic [N_INPUTS-1:0]           in_valid;
   logic [N_INPUTS-1:0]           in_last;
   logic [N_INPUTS-1:0]           in_ready;
   logic [BUS_WIDTH-1:0]          out_data;
   logic                          out_valid;
   logic                          out_last;
   logic [SEL_WIDTH-1:0]          out_sel;
   logic                          out_ready;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, out_sel
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_sel
   );

endinterface

// File: rtl/bus_arb_mux_rr_arbiter.sv
// rr_arbiter: combinational request picker.
//   i_req   : N-wide request vector
//   i_base  : search start index (only used when i_mode = 1)
//   i_mode  : 0 = search from index 0 upward, 1 = search from i_base upward with wrap
//   o_grant : one-hot grant (all zero when no request)
//   o_idx   : encoded index of the granted request
//   o_any   : at least one request present
module rr_arbiter #(
   parameter int N_INPUTS  = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic [N_INPUTS-1:0]  i_req,
   input  logic [SEL_WIDTH-1:0] i_base,
   input  logic                 i_mode,
   output logic [N_INPUTS-1:0]  o_grant,
   output logic [SEL_WIDTH-1:0] o_idx,
   output logic                 o_any
);

   int w_c;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_c     = 0;
      for (int k = 0; k < N_INPUTS; k++) begin
         w_c = (i_mode ? int'(i_base) : 0) + k;
         // Explicit wrap so non-power-of-two channel counts stay in range.
         if (w_c >= N_INPUTS) w_c = w_c - N_INPUTS;
         if (!o_any && i_req[w_c]) begin
            o_any        = 1'b1;
            o_idx        = w_c[SEL_WIDTH-1:0];
            o_grant[w_c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: N-input bus mux with internal arbitration, packet locking and a
// registered output stage.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : bus_arb_mux_if slave modport (upstream beats, downstream beat)
//   o_state    : current grant FSM state, for observation
// A grant taken on a non-last beat is held (LOCKED) until that channel's last
// beat transfers, so packets are never interleaved.
module bus_arb_mux
   import bus_pkg::*;
#(
   parameter int BUS_WIDTH = 32,
   parameter int N_INPUTS  = 4,
   parameter int ARB_MODE  = ARB_RR,
   parameter int SEL_WIDTH = clog2(N_INPUTS)
) (
   input  logic         clk,
   input  logic         rst_n,
   bus_arb_mux_if.slave bus,
   output state_t       o_state
);

   state_t               r_state, w_state_nxt;
   logic [SEL_WIDTH-1:0] r_lock_idx, w_lock_idx_nxt;
   logic [SEL_WIDTH-1:0] r_rr_ptr, w_rr_ptr_nxt;
   logic [BUS_WIDTH-1:0] r_out_data;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic [SEL_WIDTH-1:0] r_out_sel;

   logic                 w_can_load;
   logic [N_INPUTS-1:0]  w_arb_grant;
   logic [SEL_WIDTH-1:0] w_arb_idx;
   logic                 w_arb_any;
   logic [SEL_WIDTH-1:0] w_g;
   logic [N_INPUTS-1:0]  w_in_ready;
   logic                 w_xfer;
   logic                 w_g_last;
   logic [BUS_WIDTH-1:0] w_g_data;

   assign w_can_load = !r_out_valid || bus.out_ready;

   rr_arbiter #(
      .N_INPUTS  (N_INPUTS),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_arb (
      .i_req   (bus.in_valid),
      .i_base  (r_rr_ptr),
      .i_mode  (ARB_MODE == ARB_RR),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_any   (w_arb_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_lock_idx <= '0;
         r_rr_ptr   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_idx <= w_lock_idx_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_lock_idx_nxt = r_lock_idx;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_g            = w_arb_idx;
      w_in_ready     = '0;
      w_xfer         = 1'b0;
      w_g_last       = 1'b0;

      if (r_state == LOCKED) begin
         // Grant stays with the locked channel even while it is idle (bubble).
         w_g                    = r_lock_idx;
         w_in_ready[r_lock_idx] = w_can_load;
      end else if (w_can_load && w_arb_any) begin
         w_in_ready = w_arb_grant;
      end

      // Nothing is accepted while reset is held.
      if (!rst_n) w_in_ready = '0;

      w_xfer   = |(w_in_ready & bus.in_valid);
      w_g_last = bus.in_last[w_g];

      if (w_xfer) begin
         if (w_g_last) begin
            w_state_nxt = IDLE;
            if (ARB_MODE == ARB_RR) begin
               w_rr_ptr_nxt = (int'(w_g) == N_INPUTS - 1) ? '0 : w_g + 1'b1;
            end
         end else begin
            w_state_nxt    = LOCKED;
            w_lock_idx_nxt = w_g;
         end
      end
   end

   assign w_g_data = bus.in_data[int'(w_g)*BUS_WIDTH +: BUS_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_sel   <= '0;
      end else if (w_xfer) begin
         r_out_data  <= w_g_data;
         r_out_valid <= 1'b1;
         r_out_last  <= w_g_last;
         r_out_sel   <= w_g;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;
   assign bus.out_sel   = r_out_sel;
   assign o_state       = r_state;

endmodule
